// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-device command sender: request-to-send, bit shifting on device clocks,
// line-ACK check and 0xFA response wait. Define PS2_SEQ_RESEND_EN to resend on 0xFE.
module ps2_cmd_sequencer #(
    parameter int inhibitCycles = 2000,
    parameter int timeoutBits   = 16,
    parameter int timeoutCycles = 40000,
    parameter int maxRetries    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmdValid,
    input  logic [7:0] cmdData,
    input  logic       cmdHasArg,
    input  logic [7:0] cmdArg,
    output logic       cmdReady,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    input  logic [7:0] rxData,
    input  logic       rxDataReady,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] errCode,
    output logic [2:0] debugState
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] INHIBIT  = 3'd1;
    localparam logic [2:0] START    = 3'd2;
    localparam logic [2:0] SHIFT    = 3'd3;
    localparam logic [2:0] WAITRESP = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] FAIL     = 3'd6;

    localparam int phaseBits = (inhibitCycles > 4) ? $clog2(inhibitCycles) : 2;
    localparam int retryBits = (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
    localparam logic [phaseBits-1:0]   inhibitLast  = phaseBits'(inhibitCycles - 1);
    localparam logic [phaseBits-1:0]   startLast    = phaseBits'(3);
    localparam logic [timeoutBits-1:0] timeoutLimit = timeoutBits'(timeoutCycles);
    localparam logic [retryBits-1:0]   retryLimit   = retryBits'(maxRetries);

    logic [2:0]             state;
    logic [1:0]             clkSync;
    logic [1:0]             dataSync;
    logic                   clkPrev;
    logic                   rxPrev;
    logic [phaseBits-1:0]   phaseCnt;
    logic [timeoutBits-1:0] timeCnt;
    logic [3:0]             bitCnt;
    logic [retryBits-1:0]   retryCnt;
    logic [7:0]             curByte;
    logic [7:0]             argByte;
    logic                   argPending;

    logic fallEdge;
    logic rxRise;
    logic timedOut;
    logic timeSat;
    logic oddParity;
    logic resendAllowed;

    assign fallEdge  = clkPrev & ~clkSync[1];
    assign rxRise    = rxDataReady & ~rxPrev;
    assign timedOut  = (timeCnt >= timeoutLimit);
    assign timeSat   = (timeCnt == {timeoutBits{1'b1}});
    assign oddParity = ~^curByte;

`ifdef PS2_SEQ_RESEND_EN
    assign resendAllowed = (retryCnt != retryLimit);
`else
    assign resendAllowed = 1'b0;
`endif

    assign cmdReady   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign ps2ClkOe   = (state == INHIBIT) || (state == START);
    assign done       = (state == DONE);
    assign error      = (state == FAIL);
    assign debugState = state;

    // The PS/2 lines idle high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
            rxPrev   <= 1'b0;
        end else begin
            clkSync  <= {clkSync[0], ps2ClkIn};
            dataSync <= {dataSync[0], ps2DataIn};
            clkPrev  <= clkSync[1];
            rxPrev   <= rxDataReady;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ps2DataOe  <= 1'b0;
            errCode    <= 2'd0;
            phaseCnt   <= '0;
            timeCnt    <= '0;
            bitCnt     <= 4'd0;
            retryCnt   <= '0;
            curByte    <= 8'd0;
            argByte    <= 8'd0;
            argPending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        curByte    <= cmdData;
                        argByte    <= cmdArg;
                        argPending <= cmdHasArg;
                        retryCnt   <= '0;
                        errCode    <= 2'd0;
                        phaseCnt   <= '0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (phaseCnt == inhibitLast) begin
                        phaseCnt  <= '0;
                        ps2DataOe <= 1'b1;
                        state     <= START;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                START: begin
                    if (phaseCnt == startLast) begin
                        timeCnt <= '0;
                        bitCnt  <= 4'd0;
                        state   <= SHIFT;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // bitCnt holds the number of falling edges already seen.
                    if (fallEdge) begin
                        timeCnt <= '0;
                        bitCnt  <= bitCnt + 4'd1;
                        if (bitCnt < 4'd8) begin
                            ps2DataOe <= ~curByte[bitCnt[2:0]];
                        end else if (bitCnt == 4'd8) begin
                            ps2DataOe <= ~oddParity;
                        end else if (bitCnt == 4'd9) begin
                            ps2DataOe <= 1'b0;
                        end else if (dataSync[1]) begin
                            errCode <= 2'd1;
                            state   <= FAIL;
                        end else begin
                            state <= WAITRESP;
                        end
                    end else if (timedOut) begin
                        errCode   <= 2'd2;
                        ps2DataOe <= 1'b0;
                        state     <= FAIL;
                    end else if (!timeSat) begin
                        timeCnt <= timeCnt + 1'b1;
                    end
                end
                WAITRESP: begin
                    if (rxRise) begin
                        if (rxData == 8'hFA) begin
                            if (argPending) begin
                                curByte    <= argByte;
                                argPending <= 1'b0;
                                phaseCnt   <= '0;
                                state      <= INHIBIT;
                            end else begin
                                state <= DONE;
                            end
                        end else if ((rxData == 8'hFE) && resendAllowed) begin
                            retryCnt <= retryCnt + 1'b1;
                            phaseCnt <= '0;
                            state    <= INHIBIT;
                        end else begin
                            errCode <= 2'd3;
                            state   <= FAIL;
                        end
                    end else if (timedOut) begin
                        errCode <= 2'd2;
                        state   <= FAIL;
                    end else if (!timeSat) begin
                        timeCnt <= timeCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAIL: begin
                    ps2DataOe <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: a PS/2 device model clocks frames, returns ACK and responses;
// a scenario-level model predicts frame bytes and the final outcome of each command.
`timescale 1ns/1ps
module tb_ps2_cmd_sequencer;
  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmdValid = 1'b0;
  logic [7:0] cmdData = 8'd0;
  logic       cmdHasArg = 1'b0;
  logic [7:0] cmdArg = 8'd0;
  logic       cmdReady;
  logic       ps2ClkIn;
  logic       ps2DataIn;
  logic       ps2ClkOe;
  logic       ps2DataOe;
  logic [7:0] rxData = 8'd0;
  logic       rxDataReady = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] errCode;
  logic [2:0] debugState;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  // clock / reset block
  always #5 clk = ~clk;

  // open-drain lines: either side can pull low
  assign ps2ClkIn  = dev_clk & ~ps2ClkOe;
  assign ps2DataIn = dev_data & ~ps2DataOe;

  ps2_cmd_sequencer #(
    .inhibitCycles(INH),
    .timeoutBits(10),
    .timeoutCycles(TO),
    .maxRetries(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmdValid(cmdValid),
    .cmdData(cmdData),
    .cmdHasArg(cmdHasArg),
    .cmdArg(cmdArg),
    .cmdReady(cmdReady),
    .ps2ClkIn(ps2ClkIn),
    .ps2DataIn(ps2DataIn),
    .ps2ClkOe(ps2ClkOe),
    .ps2DataOe(ps2DataOe),
    .rxData(rxData),
    .rxDataReady(rxDataReady),
    .busy(busy),
    .done(done),
    .error(error),
    .errCode(errCode),
    .debugState(debugState)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // scoreboard and scenario
  logic [7:0] exp_q[$];
  logic       scen_nack[8];
  logic [7:0] scen_resp[8];
  int         exp_code;
  int         exp_frames;

  task automatic scen_clear();
    for (int k = 0; k < 8; k++) begin
      scen_nack[k] = 1'b0;
      scen_resp[k] = 8'hFA;
    end
  endtask

  // Walk the scenario frame by frame using the protocol rules.
  task automatic model_build(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg);
    logic [7:0] cur;
    logic       pend;
    int         fe_used;
    bit         fin;
    cur = cmd;
    pend = has_arg;
    fe_used = 0;
    fin = 0;
    exp_q.delete();
    exp_frames = 0;
    exp_code = 0;
    for (int k = 0; k < 8 && !fin; k++) begin
      exp_q.push_back(cur);
      exp_frames++;
      if (scen_nack[k]) begin
        exp_code = 1;
        fin = 1;
      end else if (scen_resp[k] == 8'hFA) begin
        if (pend) begin
          cur = arg;
          pend = 0;
        end else begin
          exp_code = 0;
          fin = 1;
        end
      end else if (scen_resp[k] == 8'hFE) begin
`ifdef PS2_SEQ_RESEND_EN
        if (fe_used == MR) begin
          exp_code = 3;
          fin = 1;
        end else begin
          fe_used++;
        end
`else
        exp_code = 3;
        fin = 1;
`endif
      end else begin
        exp_code = 3;
        fin = 1;
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    cmdValid = 1'b0;
    rxDataReady = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
    @(negedge clk);
    cmdValid = 1'b1;
    cmdData = c;
    cmdHasArg = h;
    cmdArg = a;
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] b);
    repeat (4) @(negedge clk);
    rxData = b;
    rxDataReady = 1'b1;
    repeat (3) @(negedge clk);
    rxDataReady = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int w;
    w = 0;
    while (cmdReady !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = (cmdReady === 1'b1);
  endtask

  // Device side of one frame: waits for the request-to-send, then clocks n_edges edges.
  task automatic dev_frame(input logic nack, input int n_edges, input bit in_shift,
                           output logic [7:0] got, output logic par, output logic stp, output bit ok);
    int w;
    ok = 1;
    got = 8'd0;
    par = 1'b0;
    stp = 1'b0;
    if (!in_shift) begin
      w = 0;
      while (ps2ClkOe !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (ps2ClkOe !== 1'b1) ok = 0;
      w = 0;
      while (ok && ps2ClkOe !== 1'b0 && w < INH + 50) begin
        @(negedge clk);
        w++;
      end
      if (ps2ClkOe !== 1'b0) ok = 0;
    end
    if (ok) begin
      check_eq("start_bit_oe", ps2DataOe, 1);
      for (int n = 1; n <= n_edges; n++) begin
        repeat (5) @(negedge clk);
        if (n == 11) dev_data = nack;
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        if (n <= 8) got[n-1] = ~ps2DataOe;
        else if (n == 9) par = ~ps2DataOe;
        else if (n == 10) stp = ~ps2DataOe;
        dev_clk = 1'b1;
        if (n == 11) begin
          @(negedge clk);
          dev_data = 1'b1;
        end
      end
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg,
                         input bit timing, input bit spurious);
    int d0, e0, k;
    bit ok;
    logic [7:0] got, want;
    logic par, stp;
    model_build(cmd, has_arg, arg);
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(cmd, has_arg, arg);
    check_eq("accept_busy_rdy_clkoe", {busy, cmdReady, ps2ClkOe}, 3'b101);
    if (timing) begin
      k = 0;
      while (ps2DataOe !== 1'b1 && k < INH + 10) begin
        @(negedge clk);
        k++;
      end
      check_eq("inhibit_len", k, INH);
      k = 0;
      while (ps2ClkOe !== 1'b0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_eq("start_len", k, 4);
    end
    if (spurious) begin
      rxData = 8'hFE;
      rxDataReady = 1'b1;
      @(negedge clk);
      rxDataReady = 1'b0;
    end
    ok = 1;
    for (int f = 0; f < exp_frames && ok; f++) begin
      dev_frame(scen_nack[f], 11, timing && (f == 0), got, par, stp, ok);
      check_eq("frame_seen", ok, 1);
      if (ok) begin
        want = exp_q.pop_front();
        check_eq("frame_byte", got, want);
        check_eq("frame_parity", par, ($countones(want) % 2 == 0) ? 1 : 0);
        check_eq("frame_stop", stp, 1);
        if (!scen_nack[f]) send_resp(scen_resp[f]);
      end
    end
    if (ok) begin
      wait_idle(ok);
      check_eq("return_idle", ok, 1);
      check_eq("frames_left", exp_q.size(), 0);
    end
    repeat (2) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, (exp_code == 0) ? 1 : 0);
    check_eq("error_pulses", err_cnt - e0, (exp_code != 0) ? 1 : 0);
    check_eq("err_code", errCode, exp_code);
    check_eq("oe_released", {ps2ClkOe, ps2DataOe}, 0);
    if (!ok) do_reset();
  endtask

  initial begin
    int d0, e0, k;
    bit ok;
    logic [7:0] got, b;
    logic par, stp;
    int r;

    repeat (3) @(negedge clk);
    check_eq("rst_ready_busy", {cmdReady, busy}, 2'b10);
    check_eq("rst_oes", {ps2ClkOe, ps2DataOe}, 0);
    check_eq("rst_done_err", {done, error}, 0);
    check_eq("rst_errcode", errCode, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    scen_clear();
    run_txn(8'hF4, 1'b0, 8'h00, 1, 0);

    scen_clear();
    run_txn(8'hED, 1'b1, 8'h02, 0, 1);

    scen_clear();
    scen_nack[0] = 1'b1;
    run_txn(8'hFF, 1'b0, 8'h00, 0, 0);

    scen_clear();
    scen_resp[0] = 8'hFE;
    scen_resp[1] = 8'hFE;
    run_txn(8'hF4, 1'b0, 8'h00, 0, 0);

    scen_clear();
    for (int i = 0; i < 4; i++) scen_resp[i] = 8'hFE;
    run_txn(8'hF3, 1'b0, 8'h00, 0, 0);

    // device stops clocking after edge 5
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'hF4, 1'b0, 8'h00);
    dev_frame(1'b0, 5, 0, got, par, stp, ok);
    check_eq("to_frame_seen", ok, 1);
    k = 0;
    while (error !== 1'b1 && k < TO + 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("to_in_window", (k + 8 >= TO && k + 8 <= TO + 8) ? 1 : 0, 1);
    check_eq("to_errcode", errCode, 2);
    @(negedge clk);
    check_eq("to_oes", {ps2ClkOe, ps2DataOe}, 0);
    check_eq("to_ready", cmdReady, 1);
    check_eq("to_pulses", {done_cnt - d0, err_cnt - e0}, {32'd0, 32'd1});

    // reset while shifting, after edge 4 (bit 3 of 0xF4 is 0, so data is pulled low)
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'hF4, 1'b0, 8'h00);
    dev_frame(1'b0, 4, 0, got, par, stp, ok);
    check_eq("mid_frame_bits", got[3:0], 4'h4);
    check_eq("pre_reset_data_oe", ps2DataOe, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_oes", {ps2ClkOe, ps2DataOe}, 0);
    check_eq("rst_mid_ready", {cmdReady, busy}, 2'b10);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
    check_eq("rst_mid_errcode", errCode, 0);

    for (int t = 0; t < 30; t++) begin
      scen_clear();
      for (int i = 0; i < 8; i++) begin
        scen_nack[i] = ($urandom_range(0, 11) == 0);
        r = $urandom_range(0, 9);
        if (r < 6) scen_resp[i] = 8'hFA;
        else if (r < 9) scen_resp[i] = 8'hFE;
        else begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hFA || b == 8'hFE) b = 8'h00;
          scen_resp[i] = b;
        end
      end
      run_txn(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              0, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Host-to-device command sequencer for the PS/2 keyboard port. It accepts a command byte plus an optional argument byte, for example 0xED (set LEDs) followed by its LED mask. For each byte it:
- runs the PS/2 host request-to-send sequence,
- shifts the byte out on device-generated clocks,
- checks the line ACK bit,
- waits for the keyboard's 0xFA response, which arrives through the existing PS/2 receiver.

It sits beside the PS/2 decoder, owns the open-drain drive enables for the PS/2 clock and data lines, and reports completion or one of three error codes.

## Interface
Parameters:
- inhibitCycles, 2000: clk cycles the PS/2 clock is held low before the start bit (≥100 µs).
- timeoutBits, 16: width of the timeout counter.
- timeoutCycles, 40000: maximum clk cycles between device clock falling edges, or while waiting for a response.
- maxRetries, 3: number of retransmits after a 0xFE response (used only with PS2_SEQ_RESEND_EN).

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- cmdValid  in  1  command request.
- cmdData  in  8  command byte.
- cmdHasArg  in  1  an argument byte follows the command.
- cmdArg  in  8  argument byte.
- cmdReady  out  1  high only in IDLE.
- ps2ClkIn  in  1  raw PS/2 clock line (asynchronous).
- ps2DataIn  in  1  raw PS/2 data line (asynchronous).
- ps2ClkOe  out  1  1 = pull PS/2 clock low.
- ps2DataOe  out  1  1 = pull PS/2 data low.
- rxData  in  8  byte from the PS/2 receiver.
- rxDataReady  in  1  receiver ready level; its rising edge marks a new byte.
- busy  out  1  high when state ≠ IDLE; the decoder ignores received bytes while busy.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on failure.
- errCode  out  2  0 none, 1 no line ACK, 2 timeout, 3 bad response / retries exhausted. Held until the next accepted command.

## Operation
- ps2ClkIn and ps2DataIn pass through a 2-FF synchronizer. A clock falling edge is synchronized sample high → low. rxDataReady rising edge is detected against its previous value.
- States and transitions:
  - IDLE: the command is accepted when cmdValid & cmdReady. Latch cmdData, cmdHasArg and cmdArg; the current byte is cmdData; the retry count clears.
  - INHIBIT: ps2ClkOe=1 for inhibitCycles cycles.
  - START: ps2ClkOe=1 and ps2DataOe=1 for 4 cycles. Then ps2ClkOe=0 and go to SHIFT with ps2DataOe still 1 (start bit 0).
  - SHIFT: on each falling edge, edge counter n (1..11):
    - n=1..8: ps2DataOe = ~byte[n-1] (LSB first).
    - n=9: parity bit, odd parity = ~^byte.
    - n=10: ps2DataOe=0 (stop bit 1).
    - n=11: sample ps2DataIn. 0 → WAITRESP; 1 → FAIL with code 1.
  - WAITRESP: wait for a new rxData byte.
    - 0xFA with argument still pending: current byte = cmdArg, go to INHIBIT.
    - 0xFA otherwise: DONE.
    - 0xFE: see Configuration.
    - any other byte: FAIL with code 3.
  - DONE: pulse done for 1 cycle, return to IDLE.
  - FAIL: pulse error for 1 cycle, set errCode, release both OEs, return to IDLE.
- Timeout:
  - The counter clears on entering SHIFT or WAITRESP and on every falling edge in SHIFT.
  - Reaching timeoutCycles → FAIL with code 2.
  - The counter saturates; it never wraps.
- Simultaneous events:
  - A falling edge and a timeout in the same cycle: the edge wins.
  - A response byte and a timeout in the same cycle: the byte wins.
- A rxDataReady rising edge outside WAITRESP is ignored.

## Timing
- Reset values: state IDLE; cmdReady=1; ps2ClkOe=0; ps2DataOe=0; busy=0; done=0; error=0; errCode=0; all counters 0.
- Reset during any state: both OEs are 0 at the next clk edge and the command is discarded (no done, no error).
- Acceptance cycle T: cmdReady=0, busy=1 and ps2ClkOe=1 from T+1.
- ps2DataOe rises at T+1+inhibitCycles.
- ps2ClkOe falls at T+1+inhibitCycles+4.
- Data changes 3 cycles after the physical falling edge: 2 synchronizer stages plus 1 register.
- done or error is asserted the cycle after the deciding event. cmdReady=1 the cycle after that.

## Configuration
- Macro: PS2_SEQ_RESEND_EN.
- Defined:
  - 0xFE in WAITRESP increments the retry count and resends the current byte via INHIBIT.
  - A 0xFE arriving after maxRetries resends → FAIL with code 3.
- Undefined: 0xFE → FAIL with code 3 immediately, and maxRetries is unused.

## Test plan
- Command 0xF4, no argument; device model clocks 11 edges, ACKs, sends 0xFA. Required: bits 0,0,1,0,1,1,1,1 observed on data, parity 0, stop 1; single done pulse; errCode=0.
- Command 0xED with argument 0x02; device sends 0xFA after each byte. Required: two full frames, second frame carries 0x02 with parity 0; exactly one done pulse.
- Command 0xFF; device leaves data high on edge 11. Required: error pulse, errCode=1, both OEs 0.
- Command 0xF4; device stops clocking after edge 5. Required: error after timeoutCycles, errCode=2.
- 0xFE responses:
  - With PS2_SEQ_RESEND_EN, responses 0xFE, 0xFE, 0xFA → 3 frames of the same byte, then done.
  - Four 0xFE responses → errCode=3.
  - Without the macro, the first 0xFE → errCode=3.
- reset asserted mid-SHIFT (edge 4). Required: OEs 0 next cycle, cmdReady=1, no done or error pulse.
